pixel_buffer_drain: RTL and testbench

- Receiving end of the pixel-entry write interface driven by the intersection/shading stage (we / full / pixel_buffer_entry_t).
- Buffers {color, rayID} entries in a FIFO.
- Drains them one at a time to the frame-buffer write port using a req/ack handshake, with address = FB_BASE + rayID.
- Counts drained pixels and pulses frame_done at end of frame.

---
 rtl/pixel_buffer_drain_pkg.sv | 16 +
 rtl/pixel_buffer_drain.sv | 124 ++++++++++++
 tb/tb_pixel_buffer_drain.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_buffer_drain_pkg.sv
// Shared entry types for the pixel-entry write interface between the
// shading stage and pixel_buffer_drain.
package pixel_buffer_drain_pkg;

  localparam int COLOR_W  = 24;
  localparam int RAY_ID_W = 19;

  typedef logic [COLOR_W-1:0]  color_t;
  typedef logic [RAY_ID_W-1:0] ray_id_t;

  typedef struct packed {
    color_t  color;
    ray_id_t ray_id;
  } pixel_buffer_entry_t;

endpackage

// File: rtl/pixel_buffer_drain.sv
// Buffers {color, ray_id} entries and drains them to the frame buffer over req/ack.
// Optional macro PIXEL_BUF_ALMOST_FULL_EN raises full one slot early for registered-stall upstreams.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | output register empty, fb_req low; pops head when FIFO non-empty
//   REQ   | fb_req high, fb_addr/fb_data held until fb_ack
module pixel_buffer_drain
  import pixel_buffer_drain_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int NUM_PIXELS = 307200,
  parameter int FB_BASE    = 0,
  parameter int ADDR_W     = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  pixel_buffer_entry_t pixel_entry_in,
  output logic                full,
  output logic                fb_req,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOR_W-1:0]  fb_data,
  input  logic                fb_ack,
  output logic                frame_done,
  output logic                overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PIX_W = $clog2(NUM_PIXELS + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state, state_nxt;
  pixel_buffer_entry_t mem [DEPTH];
  pixel_buffer_entry_t head;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [PIX_W-1:0]    pix_count;
  logic [ADDR_W-1:0]   addr_q, addr_calc;
  logic [COLOR_W-1:0]  data_q;
  logic                ovf_q;
  logic                room, push, pop, empty, ack_fire;

  assign empty = (count == '0);

`ifdef PIXEL_BUF_ALMOST_FULL_EN
  // full rises one slot early; the final slot still accepts the stall-lag write
  assign full = (count >= CNT_W'(DEPTH - 1));
  assign room = (count != CNT_W'(DEPTH));
`else
  assign full = (count == CNT_W'(DEPTH));
  assign room = !full;
`endif

  assign push = we && room;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (fb_ack) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
    endcase
  end

  assign ack_fire   = (state == REQ) && fb_ack;
  assign frame_done = ack_fire && (pix_count == PIX_W'(NUM_PIXELS - 1));

  assign head      = mem[rd_ptr];
  assign addr_calc = ADDR_W'(FB_BASE) + ADDR_W'(head.ray_id);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pixel_entry_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_count <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop) begin
        addr_q <= addr_calc;
        data_q <= head.color;
      end
      if (we && !room) ovf_q <= 1'b1;
      if (ack_fire) begin
        if (frame_done) pix_count <= '0;
        else            pix_count <= pix_count + PIX_W'(1);
      end
    end
  end

  assign fb_req   = (state == REQ);
  assign fb_addr  = addr_q;
  assign fb_data  = data_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pixel_buffer_drain.sv
// Directed self-checking bench for pixel_buffer_drain (DEPTH=4, NUM_PIXELS=8, FB_BASE=0x100).
module tb_pixel_buffer_drain;
  import pixel_buffer_drain_pkg::*;

  localparam int DEPTH      = 4;
  localparam int NUM_PIXELS = 8;
  localparam int FB_BASE    = 'h100;
  localparam int ADDR_W     = 20;

  logic                clk = 1'b0;
  logic                rst, we, fb_ack;
  pixel_buffer_entry_t pixel_entry_in;
  logic                full, fb_req, frame_done, overflow;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOR_W-1:0]  fb_data;

  int checks = 0;
  int errors = 0;

  pixel_buffer_drain #(
    .DEPTH(DEPTH), .NUM_PIXELS(NUM_PIXELS), .FB_BASE(FB_BASE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .pixel_entry_in(pixel_entry_in), .full(full),
    .fb_req(fb_req), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ack(fb_ack),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [23:0] c, input logic [18:0] r, input logic a);
    we                    = w;
    pixel_entry_in.color  = c;
    pixel_entry_in.ray_id = r;
    fb_ack                = a;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rst_full", full, 0);
    check("rst_req", fb_req, 0);
    check("rst_ovf", overflow, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_done", frame_done, 0);
  endtask

  function automatic logic [23:0] color_of(input int k);
    return 24'h3C0000 + 24'(k) * 24'h010203;
  endfunction

  initial begin
    int stall [5] = '{0, 3, 1, 5, 2};
    int k;

    // single entry, ack tied high: fb_req for exactly one cycle, two cycles after we
    do_reset();
    drive(1'b1, 24'h445566, 19'd7, 1'b1);
    check("t1_req_c0", fb_req, 0);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    check("t1_req_c1", fb_req, 0);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    check("t1_req_c2", fb_req, 1);
    check("t1_addr", fb_addr, 'h107);
    check("t1_data", fb_data, 'h445566);
    check("t1_done", frame_done, 0);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    check("t1_req_c3", fb_req, 0);
    check("t1_ovf", overflow, 0);

    // fill with ack low: DEPTH+1 accepted, last write dropped
    do_reset();
    for (int c = 0; c < DEPTH + 2; c++) begin
      drive(1'b1, 24'hA00000 + 24'(c), 19'h10 + 19'(c), 1'b0);
      check($sformatf("t2_full_c%0d", c), full, (c == DEPTH + 1) ? 1 : 0);
      cyc();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, '0, '0, 1'b0);
      check("t2_ovf", overflow, 1);
      check("t2_full_hold", full, 1);
      check("t2_req_hold", fb_req, 1);
      check("t2_addr_hold", fb_addr, 'h110);
      check("t2_data_hold", fb_data, 'hA00000);
      cyc();
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      check($sformatf("t2_req_%0d", i), fb_req, 1);
      check($sformatf("t2_addr_%0d", i), fb_addr, 'h110 + i);
      check($sformatf("t2_data_%0d", i), fb_data, 'hA00000 + i);
      check($sformatf("t2_done_%0d", i), frame_done, 0);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("t2_req_end", fb_req, 0);
    check("t2_full_end", full, 0);
    check("t2_ovf_sticky", overflow, 1);

    // ack stalls: outputs stable while waiting, order preserved, frame_done on 8th ack
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < DEPTH + 1; c++) begin
        k = b * 5 + c;
        drive(1'b1, color_of(k), 19'h20 + 19'(k), 1'b0);
        cyc();
      end
      for (int i = 0; i < 5; i++) begin
        k = b * 5 + i;
        for (int s = 0; s < stall[i]; s++) begin
          drive(1'b0, '0, '0, 1'b0);
          check($sformatf("t3_req_stall_%0d", k), fb_req, 1);
          check($sformatf("t3_addr_stall_%0d", k), fb_addr, 'h120 + k);
          check($sformatf("t3_data_stall_%0d", k), fb_data, color_of(k));
          check($sformatf("t3_done_stall_%0d", k), frame_done, 0);
          cyc();
        end
        drive(1'b0, '0, '0, 1'b1);
        check($sformatf("t3_req_%0d", k), fb_req, 1);
        check($sformatf("t3_addr_%0d", k), fb_addr, 'h120 + k);
        check($sformatf("t3_data_%0d", k), fb_data, color_of(k));
        check($sformatf("t3_done_%0d", k), frame_done, (k == 7) ? 1 : 0);
        cyc();
      end
      drive(1'b0, '0, '0, 1'b0);
      check($sformatf("t3_idle_b%0d", b), fb_req, 0);
    end

    // frame wrap with ack tied high: one pixel per cycle, frame_done on acks 8 and 16
    do_reset();
    for (int c = 0; c < 19; c++) begin
      drive(c < 16, color_of(c), 19'h30 + 19'(c), 1'b1);
      if (c >= 2 && c < 18) begin
        check($sformatf("t4_req_%0d", c), fb_req, 1);
        check($sformatf("t4_addr_%0d", c), fb_addr, 'h130 + c - 2);
        check($sformatf("t4_done_%0d", c), frame_done, ((c - 2) % 8 == 7) ? 1 : 0);
      end else begin
        check($sformatf("t4_req_%0d", c), fb_req, 0);
        check($sformatf("t4_done_%0d", c), frame_done, 0);
      end
      cyc();
    end

    // simultaneous push/pop at count = DEPTH-1
    do_reset();
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b1, color_of(c), 19'h40 + 19'(c), 1'b0);
      cyc();
    end
    drive(1'b1, color_of(DEPTH), 19'h40 + 19'(DEPTH), 1'b1);
    check("t5_full_pre", full, 0);
    check("t5_addr_pre", fb_addr, 'h140);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    check("t5_full_post", full, 0);
    check("t5_ovf", overflow, 0);
    check("t5_addr_post", fb_addr, 'h141);
    cyc();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      check($sformatf("t5_req_%0d", i), fb_req, 1);
      check($sformatf("t5_addr_%0d", i), fb_addr, 'h140 + i);
      check($sformatf("t5_data_%0d", i), fb_data, color_of(i));
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("t5_req_end", fb_req, 0);

    // reset mid-transfer abandons queued entries
    do_reset();
    for (int c = 0; c < DEPTH + 1; c++) begin
      drive(1'b1, color_of(c), 19'h50 + 19'(c), 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("t6_req_before", fb_req, 1);
    check("t6_full_before", full, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b1, 24'hABCDEF, 19'h55, 1'b0);
    check("t6_req_after", fb_req, 0);
    check("t6_full_after", full, 0);
    check("t6_ovf_after", overflow, 0);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    check("t6_req_c1", fb_req, 0);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    check("t6_req_c2", fb_req, 1);
    check("t6_addr", fb_addr, 'h155);
    check("t6_data", fb_data, 'hABCDEF);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    check("t6_req_end", fb_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
